buffer_ctrl: RTL and testbench
==============================

# buffer_ctrl

Pointer and occupancy controller for the parallel-access circular `Buffer` scratchpad. It sits directly upstream of the buffer and drives its `wen`, `waddr` and `raddr`. The producer's data bus connects straight to the buffer's `din`, and the buffer's `dout` goes straight to the consumer. The controller adds valid/ready handshakes on both sides, FIFO-style occupancy tracking with wrap-around for any `DEPTH`, and a sliding-window read advance that lets overlapping windows be re-read.

## Interface
Parameters:
- `DEPTH`, 4: buffer depth in words; must equal the buffer instance's `DEPTH`.
- `PAR_WRITE`, 1: words written per accepted push; 1..`DEPTH`.
- `PAR_READ`, 1: words presented per read window; 1..`DEPTH`.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: pointer width.
- `CNT_WIDTH`, `$clog2(DEPTH+1)`: occupancy width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  producer presents `PAR_WRITE` words on the buffer `din`.
- `wr_ready`  out  1  room for `PAR_WRITE` words.
- `rd_valid`  out  1  at least `PAR_READ` words are readable at `buf_raddr`.
- `rd_ready`  in  1  consumer accepts the current window.
- `rd_stride`  in  `$clog2(PAR_READ)+1`  words retired on an accepted read.
- `buf_wen`  out  1  to buffer `wen`.
- `buf_waddr`  out  `ADDR_WIDTH`  to buffer `waddr` (write pointer).
- `buf_raddr`  out  `ADDR_WIDTH`  to buffer `raddr` (read pointer).
- `count`  out  `CNT_WIDTH`  words currently stored.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `flush`  in  1  synchronous clear; present only with `BUF_CTRL_FLUSH_EN`.

## Operation
- State consists of three registers: `wptr`, `rptr` and `count`. All other outputs are combinational from state and inputs.
- `wr_ready = (DEPTH - count) >= PAR_WRITE`. It depends only on `count`; a same-cycle pop never raises `wr_ready`.
- `push = wr_valid & wr_ready`. `buf_wen = push`. `buf_waddr = wptr`.
- `rd_valid = count >= PAR_READ`.
- `pop = rd_valid & rd_ready`. `buf_raddr = rptr`.
- Effective stride is `s = min(rd_stride, PAR_READ)`. With `s = 0`, the pop is accepted but nothing is retired, so the same window is re-presented.
- On push: `wptr <= wptr + PAR_WRITE`, wrapped modulo `DEPTH`.
- On pop: `rptr <= rptr + s`, wrapped modulo `DEPTH`.
- Wrap arithmetic uses an `ADDR_WIDTH+1`-bit sum.
  - For power-of-two `DEPTH`, the sum is truncated.
  - Otherwise, `DEPTH` is subtracted when the sum is `>= DEPTH`.
- `count <= count + (push ? PAR_WRITE : 0) - (pop ? s : 0)`. Simultaneous push and pop are both applied in the same cycle.
- The controller never overflows or underflows `count`. Handshake gating guarantees this; no error path exists.
- Buffer memory contents are never cleared by this block; `count = 0` masks stale data.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-transfer):
  - `wptr = rptr = count = 0`.
  - `empty = 1`, `full = 0`, `rd_valid = 0`, `buf_wen = 0`.
  - `wr_ready = 1`.
- A push accepted at edge N is written by the buffer at edge N. Its words count toward `rd_valid` from cycle N+1; write-to-read latency is 1 cycle.
- `buf_raddr` is registered. Buffer `dout` is valid in the same cycle `rd_valid` is high, so there is zero read latency.
- A pop accepted at edge N frees space visible on `wr_ready` from cycle N+1.
- `wr_valid` may drop without being accepted. Once a producer asserts `wr_valid`, it holds data stable until `wr_ready` is high.
- Back-to-back pushes and pops sustain 1 transfer per cycle per side.

## Configuration
- `BUF_CTRL_FLUSH_EN` defined:
  - The `flush` port exists.
  - While `flush` is high, `wr_ready = 0`, `rd_valid = 0` and `buf_wen = 0`.
  - At the edge, `wptr`, `rptr` and `count` go to 0. Flush overrides any push or pop in the same cycle.
- `BUF_CTRL_FLUSH_EN` undefined: the `flush` port and all flush logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset with `DEPTH=4`, `PAR_WRITE=1`, `PAR_READ=1`: assert `rst_n` low -> `count=0`, `empty=1`, `full=0`, `wr_ready=1`, `rd_valid=0`, `buf_waddr=0`, `buf_raddr=0`.
- Fill with `DEPTH=4`, `PAR_WRITE=1`: 4 pushes -> `buf_waddr` sequence 0,1,2,3,0; then `full=1` and `wr_ready=0`; a 5th `wr_valid` gives `buf_wen=0` and `count` stays 4.
- Non-power-of-two `DEPTH=6`, `PAR_WRITE=2`, `PAR_READ=3`: 3 pushes -> `buf_waddr` sequence 0,2,4,0; `rd_valid` rises the cycle after the 2nd push (`count=4`); `wr_ready=0` at `count=6`.
- Sliding window with `DEPTH=6`, `PAR_READ=3`, stride 1, buffer full: 4 pops -> `buf_raddr` sequence 0,1,2,3,4 and `count` 6,5,4,3,2; `rd_valid` drops at `count=2`. Stride 0 leaves `buf_raddr` and `count` unchanged.
- Simultaneous events with `DEPTH=4`, `PAR_WRITE=PAR_READ=1`, `count=2`: push and pop in one cycle -> `count` stays 2 and both pointers advance. At `count=4` with `rd_ready=1`, `wr_ready` stays 0 that cycle.
- Reset mid-operation: `rst_n` pulsed low between edges at `count=3` -> all outputs return to reset values immediately. With `BUF_CTRL_FLUSH_EN`, `flush=1` together with `wr_valid=1` -> `buf_wen=0`, and the next cycle shows `count=0` and `empty=1`.

Source files
------------

// File: rtl/buffer_ctrl.sv
// Pointer/occupancy controller for the circular Buffer scratchpad with sliding-window reads.
// Optional synchronous flush port enabled by defining BUF_CTRL_FLUSH_EN.
module buffer_ctrl #(
  parameter int DEPTH      = 4,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  input  logic [$clog2(PAR_READ):0]     rd_stride,
  output logic                          buf_wen,
  output logic [ADDR_WIDTH-1:0]         buf_waddr,
  output logic [ADDR_WIDTH-1:0]         buf_raddr,
  output logic [CNT_WIDTH-1:0]          count,
  output logic                          full,
  output logic                          empty
`ifdef BUF_CTRL_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int SW = $clog2(PAR_READ) + 1;
  localparam bit IS_POW2 = ((DEPTH & (DEPTH - 1)) == 0);
  localparam logic [CNT_WIDTH-1:0] WR_LIMIT = CNT_WIDTH'(DEPTH - PAR_WRITE);
  localparam logic [CNT_WIDTH-1:0] RD_MIN   = CNT_WIDTH'(PAR_READ);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] PW_CNT   = CNT_WIDTH'(PAR_WRITE);
  localparam logic [SW-1:0]        PR_SW    = SW'(PAR_READ);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  flush_w;
  logic                  push, pop;
  logic [SW-1:0]         stride_s;
  logic [CNT_WIDTH-1:0]  stride_cnt;

`ifdef BUF_CTRL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] ptr,
                                                     input logic [ADDR_WIDTH:0]   inc);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, ptr} + inc;
    if (!IS_POW2 && (sum >= (ADDR_WIDTH+1)'(DEPTH)))
      sum = sum - (ADDR_WIDTH+1)'(DEPTH);
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // Room check written as count <= DEPTH-PAR_WRITE to avoid a subtraction on count.
  assign wr_ready  = !flush_w && (count_q <= WR_LIMIT);
  assign rd_valid  = !flush_w && (count_q >= RD_MIN);
  assign push      = wr_valid && wr_ready;
  assign pop       = rd_valid && rd_ready;
  assign buf_wen   = push;
  assign buf_waddr = wptr_q;
  assign buf_raddr = rptr_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);

  assign stride_s   = (rd_stride > PR_SW) ? PR_SW : rd_stride;
  assign stride_cnt = CNT_WIDTH'(stride_s);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_w) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push)
        wptr_d = wrap_add(wptr_q, (ADDR_WIDTH+1)'(PAR_WRITE));
      if (pop)
        rptr_d = wrap_add(rptr_q, (ADDR_WIDTH+1)'(stride_s));
      count_d = count_q + (push ? PW_CNT : '0) - (pop ? stride_cnt : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl: DUT a (DEPTH=4, 1/1) and DUT b (DEPTH=6, PAR_WRITE=2, PAR_READ=3).
module tb_buffer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT a
  logic       a_wr_valid = 1'b0, a_rd_ready = 1'b0;
  logic [0:0] a_rd_stride = '0;
  logic       a_wr_ready, a_rd_valid, a_buf_wen, a_full, a_empty;
  logic [1:0] a_waddr, a_raddr;
  logic [2:0] a_count;
`ifdef BUF_CTRL_FLUSH_EN
  logic       a_flush = 1'b0;
`endif

  // DUT b
  logic       b_wr_valid = 1'b0, b_rd_ready = 1'b0;
  logic [2:0] b_rd_stride = '0;
  logic       b_wr_ready, b_rd_valid, b_buf_wen, b_full, b_empty;
  logic [2:0] b_waddr, b_raddr;
  logic [2:0] b_count;

  buffer_ctrl #(.DEPTH(4), .PAR_WRITE(1), .PAR_READ(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_stride(a_rd_stride),
    .buf_wen(a_buf_wen), .buf_waddr(a_waddr), .buf_raddr(a_raddr),
    .count(a_count), .full(a_full), .empty(a_empty)
`ifdef BUF_CTRL_FLUSH_EN
    , .flush(a_flush)
`endif
  );

  buffer_ctrl #(.DEPTH(6), .PAR_WRITE(2), .PAR_READ(3)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_stride(b_rd_stride),
    .buf_wen(b_buf_wen), .buf_waddr(b_waddr), .buf_raddr(b_raddr),
    .count(b_count), .full(b_full), .empty(b_empty)
`ifdef BUF_CTRL_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_wr_ready", a_wr_ready, 1);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_waddr", a_waddr, 0);
    check("rst_raddr", a_raddr, 0);
    check("rst_wen", a_buf_wen, 0);
    #2 rst_n = 1'b1;
    tick();

    // Fill DEPTH=4
    a_wr_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fill_waddr%0d", i), a_waddr, i);
      check($sformatf("fill_wen%0d", i), a_buf_wen, 1);
      tick();
    end
    #1;
    check("fill_waddr_wrap", a_waddr, 0);
    check("fill_full", a_full, 1);
    check("fill_wr_ready", a_wr_ready, 0);
    check("fill_5th_wen", a_buf_wen, 0);
    check("fill_count4", a_count, 4);
    tick();
    check("fill_count_hold", a_count, 4);

    // Full with pop requested: wr_ready must not rise this cycle
    a_rd_ready = 1'b1; a_rd_stride = 1'b1;
    #1;
    check("full_pop_wr_ready", a_wr_ready, 0);
    check("full_pop_rd_valid", a_rd_valid, 1);
    check("full_pop_wen", a_buf_wen, 0);
    tick();
    check("pop1_count", a_count, 3);
    check("pop1_raddr", a_raddr, 1);
    check("pop1_wr_ready", a_wr_ready, 1);
    a_wr_valid = 1'b0;
    tick();
    check("pop2_count", a_count, 2);
    check("pop2_raddr", a_raddr, 2);

    // Simultaneous push and pop at count=2
    a_wr_valid = 1'b1;
    #1;
    check("sim_wen", a_buf_wen, 1);
    tick();
    check("sim_count", a_count, 2);
    check("sim_waddr", a_waddr, 1);
    check("sim_raddr", a_raddr, 3);

    // Get to count=3, then asynchronous reset between edges
    a_rd_ready = 1'b0;
    tick();
    check("pre_rst_count", a_count, 3);
    check("pre_rst_waddr", a_waddr, 2);
    a_wr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_count", a_count, 0);
    check("mid_rst_empty", a_empty, 1);
    check("mid_rst_full", a_full, 0);
    check("mid_rst_wr_ready", a_wr_ready, 1);
    check("mid_rst_rd_valid", a_rd_valid, 0);
    check("mid_rst_waddr", a_waddr, 0);
    check("mid_rst_raddr", a_raddr, 0);
    check("mid_rst_wen", a_buf_wen, 0);
    #1 rst_n = 1'b1;
    tick();

    // DEPTH=6, PAR_WRITE=2, PAR_READ=3
    b_wr_valid = 1'b1;
    #1;
    check("b_waddr0", b_waddr, 0);
    check("b_rd_valid0", b_rd_valid, 0);
    tick();
    check("b_waddr1", b_waddr, 2);
    check("b_count1", b_count, 2);
    check("b_rd_valid1", b_rd_valid, 0);
    tick();
    check("b_waddr2", b_waddr, 4);
    check("b_count2", b_count, 4);
    check("b_rd_valid2", b_rd_valid, 1);
    tick();
    check("b_waddr3", b_waddr, 0);
    check("b_count3", b_count, 6);
    check("b_wr_ready_full", b_wr_ready, 0);
    check("b_full", b_full, 1);
    b_wr_valid = 1'b0;

    // Stride 0 re-presents the same window
    b_rd_ready = 1'b1; b_rd_stride = 3'd0;
    tick();
    check("b_s0_raddr", b_raddr, 0);
    check("b_s0_count", b_count, 6);

    // Sliding window, stride 1
    b_rd_stride = 3'd1;
    for (int unsigned i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("b_slide_raddr%0d", i), b_raddr, i);
      check($sformatf("b_slide_count%0d", i), b_count, 6 - i);
    end
    check("b_slide_rd_valid", b_rd_valid, 0);

    // Push back to 4, then oversized stride clamps to 3 and rptr wraps 4+3 -> 1
    b_wr_valid = 1'b1;
    tick();
    b_wr_valid = 1'b0;
    check("b_refill_count", b_count, 4);
    check("b_refill_waddr", b_waddr, 2);
    b_rd_stride = 3'd7;
    tick();
    b_rd_ready = 1'b0;
    check("b_clamp_raddr", b_raddr, 1);
    check("b_clamp_count", b_count, 1);

`ifdef BUF_CTRL_FLUSH_EN
    a_wr_valid = 1'b1;
    tick();
    tick();
    check("fl_pre_count", a_count, 2);
    a_flush = 1'b1;
    #1;
    check("fl_wen", a_buf_wen, 0);
    check("fl_wr_ready", a_wr_ready, 0);
    check("fl_rd_valid", a_rd_valid, 0);
    tick();
    a_flush = 1'b0; a_wr_valid = 1'b0;
    check("fl_count", a_count, 0);
    check("fl_empty", a_empty, 1);
    check("fl_waddr", a_waddr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
